hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use and branch stalls,
// multi-cycle divider handshake and a saturating stall-cycle counter.
`timescale 1ns/1ps

module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic [4:0]       writeregM,
  input  logic [4:0]       writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic             branchD,
  input  logic             divE,
  input  logic             div_done,
  input  logic             excM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic             div_start,
  output logic             div_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  div_state_e       state_q, state_d;
  logic             div_start_q, div_start_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lwstall;
  logic brstall;
  logic div_launch;
  logic divstall;

  // Register 0 is hardwired to zero, so it never carries a real dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != 5'd0);
  endfunction

  // ---------------------------------------------------------------------------
  // Forwarding selects: M stage is newer than W, so it wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    forwardAE = FWD_RF;
    forwardBE = FWD_RF;
    if (regwriteM && reg_match(writeregM, rsE))      forwardAE = FWD_M;
    else if (regwriteW && reg_match(writeregW, rsE)) forwardAE = FWD_W;
    if (regwriteM && reg_match(writeregM, rtE))      forwardBE = FWD_M;
    else if (regwriteW && reg_match(writeregW, rtE)) forwardBE = FWD_W;
  end

  assign forwardAD = regwriteM && reg_match(writeregM, rsD);
  assign forwardBD = regwriteM && reg_match(writeregM, rtD);

  // ---------------------------------------------------------------------------
  // Data hazards detected in D
  // ---------------------------------------------------------------------------
  assign lwstall = memtoregE &&
                   (reg_match(writeregE, rsD) || reg_match(writeregE, rtD));

  assign brstall = branchD &&
                   ((regwriteE && (reg_match(writeregE, rsD) || reg_match(writeregE, rtD))) ||
                    (memtoregM && (reg_match(writeregM, rsD) || reg_match(writeregM, rtD))));

  // A divide entering E from IDLE stalls immediately, before the FSM moves.
  assign div_launch = (state_q == ST_IDLE) && divE && !excM;
  assign divstall   = !rst && ((state_q == ST_WAIT) || div_launch);

  // ---------------------------------------------------------------------------
  // Stall / flush outputs; an exception overrides everything.
  // ---------------------------------------------------------------------------
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (excM) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else if (divstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (lwstall || brstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Divider handshake FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    div_start_d = 1'b0;
    if (excM) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (divE) begin
            state_d     = ST_WAIT;
            div_start_d = 1'b1;
          end
        end
        ST_WAIT: if (div_done) state_d = ST_DONE;
        // divE is still high here for the same instruction; do not relaunch.
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign div_start = div_start_q;
  assign div_busy  = (state_q == ST_WAIT);

  // ---------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign stall_cnt = stall_cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_start_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      div_start_q <= div_start_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; a second CNT_W=4 instance
// shares all inputs to exercise counter saturation.
`timescale 1ns/1ps

module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic [4:0] writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       branchD, divE, div_done, excM;

  logic        stallF, stallD, stallE;
  logic        flushD, flushE, flushM, flushW;
  logic [1:0]  forwardAE, forwardBE;
  logic        forwardAD, forwardBD;
  logic        div_start, div_busy;
  logic [31:0] stall_cnt;

  logic        s4_stallF, s4_stallD, s4_stallE;
  logic        s4_flushD, s4_flushE, s4_flushM, s4_flushW;
  logic [1:0]  s4_forwardAE, s4_forwardBE;
  logic        s4_forwardAD, s4_forwardBD;
  logic        s4_div_start, s4_div_busy;
  logic [3:0]  s4_stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .divE(divE), .div_done(div_done), .excM(excM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .div_start(div_start), .div_busy(div_busy), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .divE(divE), .div_done(div_done), .excM(excM),
    .stallF(s4_stallF), .stallD(s4_stallD), .stallE(s4_stallE),
    .flushD(s4_flushD), .flushE(s4_flushE), .flushM(s4_flushM), .flushW(s4_flushW),
    .forwardAE(s4_forwardAE), .forwardBE(s4_forwardBE),
    .forwardAD(s4_forwardAD), .forwardBD(s4_forwardBD),
    .div_start(s4_div_start), .div_busy(s4_div_busy), .stall_cnt(s4_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeregE = '0; writeregM = '0; writeregW = '0;
    regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
    memtoregE = 1'b0; memtoregM = 1'b0;
    branchD = 1'b0; divE = 1'b0; div_done = 1'b0; excM = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;

    // Reset: divstall contribution masked, other stalls still live.
    #1 divE = 1'b1;
    #1;
    check("rst_divE_stallE", stallE, 1'b0);
    check("rst_divE_stallF", stallF, 1'b0);
    divE = 1'b0;
    tick();
    check("rst_busy", div_busy, 1'b0);
    check("rst_start", div_start, 1'b0);
    check("rst_cnt", stall_cnt, 32'd0);
    check("rst_cnt4", s4_stall_cnt, 4'd0);
    memtoregE = 1'b1; writeregE = 5'd8; rtD = 5'd8;
    #1;
    check("rst_lw_stallF", stallF, 1'b1);
    clear_inputs();
    rst = 1'b0;
    tick();

    // Forwarding priority
    regwriteM = 1'b1; writeregM = 5'd5; regwriteW = 1'b1; writeregW = 5'd5;
    rsE = 5'd5; rtE = 5'd5;
    #1;
    check("fwdAE_M", forwardAE, 2'b10);
    check("fwdBE_M", forwardBE, 2'b10);
    writeregM = 5'd0;
    #1;
    check("fwdAE_W", forwardAE, 2'b01);
    check("fwdBE_W", forwardBE, 2'b01);
    regwriteW = 1'b0;
    #1;
    check("fwdAE_rf", forwardAE, 2'b00);
    writeregM = 5'd5; rsD = 5'd5; rtD = 5'd6;
    #1;
    check("fwdAD", forwardAD, 1'b1);
    check("fwdBD", forwardBD, 1'b0);
    clear_inputs();
    tick();

    // Register 0 never matches
    memtoregE = 1'b1; regwriteE = 1'b1; memtoregM = 1'b1; branchD = 1'b1;
    regwriteM = 1'b1; regwriteW = 1'b1;
    #1;
    check("r0_stallF", stallF, 1'b0);
    check("r0_flushE", flushE, 1'b0);
    check("r0_fwdAE", forwardAE, 2'b00);
    check("r0_fwdBE", forwardBE, 2'b00);
    check("r0_fwdAD", forwardAD, 1'b0);
    clear_inputs();
    tick();

    // Branch stalls
    branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd3; rsD = 5'd3;
    #1;
    check("br_E_stallF", stallF, 1'b1);
    check("br_E_flushE", flushE, 1'b1);
    check("br_E_stallE", stallE, 1'b0);
    branchD = 1'b0;
    #1;
    check("nobr_stallF", stallF, 1'b0);
    clear_inputs();
    branchD = 1'b1; memtoregM = 1'b1; writeregM = 5'd4; rtD = 5'd4;
    #1;
    check("br_M_stallD", stallD, 1'b1);
    clear_inputs();
    tick();

    // Load-use stall for one cycle
    memtoregE = 1'b1; writeregE = 5'd8; rtD = 5'd8;
    #1;
    check("lw_stallF", stallF, 1'b1);
    check("lw_stallD", stallD, 1'b1);
    check("lw_flushE", flushE, 1'b1);
    check("lw_stallE", stallE, 1'b0);
    check("lw_flushM", flushM, 1'b0);
    tick();
    clear_inputs();
    #1;
    check("lw_cnt", stall_cnt, 32'd1);

    // Divide sequence: cycle 0 launch, done pulse in cycle 10
    divE = 1'b1;
    #1;
    check("div_c0_stallE", stallE, 1'b1);
    check("div_c0_flushM", flushM, 1'b1);
    check("div_c0_flushE", flushE, 1'b0);
    check("div_c0_start", div_start, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      check($sformatf("div_c%0d_start", c), div_start, (c == 1) ? 1'b1 : 1'b0);
      check($sformatf("div_c%0d_busy", c), div_busy, 1'b1);
      check($sformatf("div_c%0d_stallE", c), stallE, 1'b1);
      if (c == 10) div_done = 1'b1;
    end
    tick();
    div_done = 1'b0;
    #1;
    check("div_c11_stallE", stallE, 1'b0);
    check("div_c11_stallF", stallF, 1'b0);
    check("div_c11_busy", div_busy, 1'b0);
    divE = 1'b0;
    tick();
    check("div_c12_cnt", stall_cnt, 32'd12);
    divE = 1'b1;
    #1;
    check("div_c12_idle", stallE, 1'b1);
    divE = 1'b0;
    tick();

    // Exception in WAIT cycle 5
    divE = 1'b1;
    tick();
    repeat (4) tick();
    check("exc_pre_busy", div_busy, 1'b1);
    excM = 1'b1;
    #1;
    check("exc_flushD", flushD, 1'b1);
    check("exc_flushE", flushE, 1'b1);
    check("exc_flushM", flushM, 1'b1);
    check("exc_flushW", flushW, 1'b1);
    check("exc_stallF", stallF, 1'b0);
    check("exc_stallE", stallE, 1'b0);
    tick();
    clear_inputs();
    #1;
    check("exc_busy", div_busy, 1'b0);
    check("exc_start", div_start, 1'b0);
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    #1;
    check("exc_late_done_busy", div_busy, 1'b0);
    check("exc_late_done_stallE", stallE, 1'b0);
    check("exc_cnt", stall_cnt, 32'd17);

    // Saturation: 20 consecutive load-use stalls
    memtoregE = 1'b1; writeregE = 5'd8; rtD = 5'd8;
    repeat (20) tick();
    clear_inputs();
    #1;
    check("sat_cnt4", s4_stall_cnt, 4'd15);
    check("sat_cnt32", stall_cnt, 32'd37);

    // Reset in the middle of a division
    divE = 1'b1;
    tick();
    divE = 1'b0;
    tick();
    check("mid_busy", div_busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_stallE", stallE, 1'b0);
    check("mid_rst_stallF", stallF, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_cnt", stall_cnt, 32'd0);
    check("mid_rst_cnt4", s4_stall_cnt, 4'd0);
    check("mid_rst_busy", div_busy, 1'b0);
    check("mid_rst_busy4", s4_div_busy, 1'b0);
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    #1;
    check("mid_stray_done_busy", div_busy, 1'b0);
    divE = 1'b1;
    tick();
    divE = 1'b0;
    #1;
    check("relaunch_start", div_start, 1'b1);
    check("relaunch_busy", div_busy, 1'b1);
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    #1;
    check("relaunch_done_busy", div_busy, 1'b0);
    check("relaunch_cnt", stall_cnt, 32'd2);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
